// File: rtl/dcache_direct_if.sv
// rtl/dcache_direct_if.sv - CPU and memory-side signal bundle for dcache_direct
interface dcache_direct_if #(
    parameter int ADDRESS_WIDTH = 32
) ();
    logic                     cpu_req_i;
    logic                     cpu_we_i;
    logic [1:0]               cpu_size_i;
    logic [ADDRESS_WIDTH-1:0] cpu_addr_i;
    logic [31:0]              cpu_wdata_i;
    logic [31:0]              cpu_rdata_o;
    logic                     stall_o;
    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [ADDRESS_WIDTH-1:0] mem_addr_o;
    logic [31:0]              mem_wdata_o;
    logic [3:0]               mem_be_o;
    logic                     mem_ack_i;
    logic [31:0]              mem_rdata_i;

    modport master (
        output cpu_req_i, cpu_we_i, cpu_size_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_rdata_i,
        input  cpu_rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_size_i, cpu_addr_i, cpu_wdata_i, mem_ack_i, mem_rdata_i,
        output cpu_rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-through no-write-allocate data cache
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_direct #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_direct_if.slave       bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
`endif
);
    localparam int INDEX_BITS = $clog2(SETS);
    localparam int TAG_BITS   = ADDRESS_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                         state_q, state_d;
    logic [SETS-1:0]                valid_q, valid_d;
    logic [TAG_BITS-1:0]            tag_q [SETS];
    logic [TAG_BITS-1:0]            tag_d [SETS];
    logic [DATA_WIDTH-1:0]          data_q [SETS];
    logic [DATA_WIDTH-1:0]          data_d [SETS];
    logic                           done_q, done_d;
    logic                           mem_req_q, mem_req_d;
    logic                           mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-3:0]       mem_waddr_q, mem_waddr_d;
    logic [DATA_WIDTH-1:0]          mem_wdata_q, mem_wdata_d;
    logic [3:0]                     mem_be_q, mem_be_d;
    logic                           stall;
    logic                           count_hit, count_miss;

    logic [INDEX_BITS-1:0]          cpu_index, mem_index;
    logic [TAG_BITS-1:0]            cpu_tag, mem_tag;
    logic                           cpu_hit, mem_hit;
    logic [3:0]                     st_be;
    logic [DATA_WIDTH-1:0]          st_wdata;

    assign cpu_index = bus.cpu_addr_i[INDEX_BITS+1:2];
    assign cpu_tag   = bus.cpu_addr_i[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign mem_index = mem_waddr_q[INDEX_BITS-1:0];
    assign mem_tag   = mem_waddr_q[ADDRESS_WIDTH-3:INDEX_BITS];
    assign cpu_hit   = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
    assign mem_hit   = valid_q[mem_index] && (tag_q[mem_index] == mem_tag);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = bus.cpu_wdata_i;
        case (bus.cpu_size_i)
            2'b00: begin
                st_be    = 4'b0001 << bus.cpu_addr_i[1:0];
                st_wdata = {4{bus.cpu_wdata_i[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {bus.cpu_addr_i[1], 1'b0};
                st_wdata = {2{bus.cpu_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        done_d      = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        stall       = 1'b0;
        count_hit   = 1'b0;
        count_miss  = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q marks the completion cycle of the access still held on the bus
                if (bus.cpu_req_i && !done_q) begin
                    count_hit  = cpu_hit;
                    count_miss = !cpu_hit;
                    if (bus.cpu_we_i) begin
                        stall       = 1'b1;
                        state_d     = WRITE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_waddr_d = bus.cpu_addr_i[ADDRESS_WIDTH-1:2];
                        mem_wdata_d = st_wdata;
                        mem_be_d    = st_be;
                    end else if (!cpu_hit) begin
                        stall       = 1'b1;
                        state_d     = FILL;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_waddr_d = bus.cpu_addr_i[ADDRESS_WIDTH-1:2];
                        mem_be_d    = 4'b1111;
                    end
                end
            end
            FILL: begin
                stall = 1'b1;
                if (bus.mem_ack_i) begin
                    state_d            = IDLE;
                    mem_req_d          = 1'b0;
                    mem_we_d           = 1'b0;
                    done_d             = 1'b1;
                    data_d[mem_index]  = bus.mem_rdata_i;
                    tag_d[mem_index]   = mem_tag;
                    valid_d[mem_index] = 1'b1;
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (bus.mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    if (mem_hit) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_be_q[b]) data_d[mem_index][8*b +: 8] = mem_wdata_q[8*b +: 8];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
        end
    end

    // stall is forced low while reset is held so an abandoned access releases the pipeline at once
    assign bus.stall_o     = stall & rst;
    assign bus.cpu_rdata_o = data_q[cpu_index];
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = {mem_waddr_q, 2'b00};
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_be_o    = mem_be_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (count_hit && hit_cnt_q != '1)   hit_cnt_d  = hit_cnt_q + 32'd1;
        if (count_miss && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    logic unused_counts;
    assign unused_counts = count_hit ^ count_miss;
`endif
endmodule

// File: tb/tb_dcache_direct.sv
// tb/tb_dcache_direct.sv - directed self-checking bench for dcache_direct
module tb_dcache_direct;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dcache_direct_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
    dcache_direct dut (.clk(clk), .rst(rst), .bus(bus), .hit_count_o(hit_count), .miss_count_o(miss_count));
`else
    dcache_direct dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          stalls, reqs;
    logic [31:0] rdata;
    logic        req_at_done;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drives one CPU access and acts as memory: acks after ack_wait request cycles
    task automatic do_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_wait, input logic [31:0] fill);
        bit done = 0;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_size_i  = size;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
        stalls = 0;
        reqs   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.mem_ack_i = 1'b0;
            if (!bus.stall_o) begin
                rdata       = bus.cpu_rdata_o;
                req_at_done = bus.mem_req_o;
                done        = 1;
                break;
            end
            stalls++;
            if (bus.mem_req_o) begin
                reqs++;
                if (reqs > ack_wait) begin
                    seen_addr       = bus.mem_addr_o;
                    seen_wdata      = bus.mem_wdata_o;
                    seen_be         = bus.mem_be_o;
                    seen_we         = bus.mem_we_o;
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = fill;
                end
            end
        end
        if (!done) check("access_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.cpu_req_i = 1'b0;
        bus.mem_ack_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_size_i  = 2'b10;
        bus.cpu_addr_i  = 32'h0;
        bus.cpu_wdata_i = 32'h0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);
        check("rst_be", {28'd0, bus.mem_be_o}, 32'd0);
        check("rst_rdata", bus.cpu_rdata_o, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // cold miss, 3 waiting request cycles
        do_access(1'b0, 2'b10, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        check("cold_stalls", stalls, 32'd5);
        check("cold_reqs", reqs, 32'd4);
        check("cold_rdata", rdata, 32'hDEADBEEF);
        check("cold_fill_addr", seen_addr, 32'h100);
        check("cold_fill_we", {31'd0, seen_we}, 32'd0);

        do_access(1'b0, 2'b10, 32'h100, 32'h0, 0, 32'h0);
        check("hit_stalls", stalls, 32'd0);
        check("hit_rdata", rdata, 32'hDEADBEEF);
        check("hit_no_req", {31'd0, req_at_done}, 32'd0);
`ifdef DCACHE_STATS_EN
        check("stat_hit1", hit_count, 32'd1);
        check("stat_miss1", miss_count, 32'd1);
`endif

        // byte store hit merges into the line
        do_access(1'b1, 2'b00, 32'h101, 32'h000000AB, 0, 32'h0);
        check("sb_stalls", stalls, 32'd2);
        check("sb_be", {28'd0, seen_be}, 32'h2);
        check("sb_wdata", seen_wdata, 32'hABABABAB);
        check("sb_we", {31'd0, seen_we}, 32'd1);
        check("sb_addr", seen_addr, 32'h100);
        check("sb_no_reissue", {31'd0, req_at_done}, 32'd0);
        do_access(1'b0, 2'b10, 32'h100, 32'h0, 0, 32'h0);
        check("sb_merge_stalls", stalls, 32'd0);
        check("sb_merge_rdata", rdata, 32'hDEADABEF);
`ifdef DCACHE_STATS_EN
        check("stat_hit3", hit_count, 32'd3);
        check("stat_miss3", miss_count, 32'd1);
`endif

        // conflict on index 0
        do_access(1'b0, 2'b10, 32'h120, 32'h0, 1, 32'h11111111);
        check("conf_stalls", stalls, 32'd3);
        check("conf_rdata", rdata, 32'h11111111);
        do_access(1'b0, 2'b10, 32'h100, 32'h0, 1, 32'hCAFEF00D);
        check("refill_stalls", stalls, 32'd3);
        check("refill_rdata", rdata, 32'hCAFEF00D);

        // word store miss does not allocate
        do_access(1'b1, 2'b10, 32'h200, 32'h12345678, 0, 32'h0);
        check("sw_be", {28'd0, seen_be}, 32'hF);
        check("sw_wdata", seen_wdata, 32'h12345678);
        check("sw_addr", seen_addr, 32'h200);
        do_access(1'b0, 2'b10, 32'h200, 32'h0, 0, 32'h0BADF00D);
        check("noalloc_stalls", stalls, 32'd2);
        check("noalloc_rdata", rdata, 32'h0BADF00D);

        // half store to upper lane
        do_access(1'b1, 2'b01, 32'h202, 32'h0000BEEF, 2, 32'h0);
        check("sh_stalls", stalls, 32'd4);
        check("sh_be", {28'd0, seen_be}, 32'hC);
        check("sh_wdata", seen_wdata, 32'hBEEFBEEF);
        do_access(1'b0, 2'b10, 32'h200, 32'h0, 0, 32'h0);
        check("sh_merge_rdata", rdata, 32'hBEEFF00D);

        // reset while a fill is outstanding
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h100;
        @(posedge clk);
        @(negedge clk);
        check("midfill_req", {31'd0, bus.mem_req_o}, 32'd1);
        rst = 1'b0;
        #1;
        check("midfill_rst_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("midfill_rst_stall", {31'd0, bus.stall_o}, 32'd0);
        bus.cpu_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_access(1'b0, 2'b10, 32'h100, 32'h0, 0, 32'h55AA55AA);
        check("post_rst_stalls", stalls, 32'd2);
        check("post_rst_rdata", rdata, 32'h55AA55AA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
